sha256_wk_scheduler: RTL

Producer side of the W/K word stream consumed by the SHA-256 round/compression stage.
- Accepts one 512-bit padded message block.
- Expands it into the 64-entry message schedule W[0..63] and pairs each word with round constant K[t].
- Presents one (W, K, index) tuple per cycle.
- Flags the final round with wk_index_complete so the downstream stage folds in the previous hash.

---
 rtl/sha256_pkg.sv | 40 ++++
 rtl/sha256_k_rom.sv | 13 +
 rtl/sha256_wk_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, small sigma functions and
// the W/K scheduler state encoding.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wk_state_e;

  localparam logic [WORD_W-1:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WORD_W-1:0] sigma0_small(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1_small(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, index -> K[index].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]        idx,
  output logic [WORD_W-1:0] k
);

  always_comb begin
    k = K_TABLE[idx];
  end

endmodule

// File: rtl/sha256_wk_scheduler.sv
// Streams the 64-word SHA-256 message schedule paired with K[t], one tuple per cycle.
// Build option SHA256_WK_PRECOMBINE_EN: cur_w carries W+K and cur_k reads 0.
module sha256_wk_scheduler
  import sha256_pkg::*;
#(
  parameter int WK_LENGTH = 64,
  localparam int IDX_W    = $clog2(WK_LENGTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [511:0]       message_block,
  input  logic               stall,
  output logic               busy,
  output logic               wk_valid,
  output logic [WORD_W-1:0]  cur_w,
  output logic [WORD_W-1:0]  cur_k,
  output logic [IDX_W-1:0]   wk_vector_index,
  output logic               wk_index_complete
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WK_LENGTH - 1);

  wk_state_e         state_q, state_d;
  logic [WORD_W-1:0] window_q [16];
  logic [WORD_W-1:0] window_d [16];
  logic [IDX_W-1:0]  index_q, index_d;
  logic              complete_q, complete_d;
  logic [WORD_W-1:0] k_word;
  logic [WORD_W-1:0] w_next;
  logic              last_round;

  sha256_k_rom u_k_rom (
    .idx (6'(index_q)),
    .k   (k_word)
  );

  assign last_round = (state_q == ST_RUN) && (index_q == LAST_IDX);
  assign w_next     = sigma1_small(window_q[14]) + window_q[9]
                    + sigma0_small(window_q[1]) + window_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      complete_q <= 1'b0;
      for (int i = 0; i < 16; i++) window_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      complete_q <= complete_d;
      for (int i = 0; i < 16; i++) window_q[i] <= window_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    complete_d = complete_q;
    for (int i = 0; i < 16; i++) window_d[i] = window_q[i];
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          index_d    = '0;
          complete_d = 1'b0;
          for (int i = 0; i < 16; i++) window_d[i] = message_block[511 - 32*i -: 32];
        end
      end
      ST_RUN: begin
        if (!stall) begin
          for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
          window_d[15] = w_next;
          // Index parks on the last round so DONE keeps reporting it.
          if (last_round) begin
            state_d    = ST_DONE;
            complete_d = 1'b1;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy              = 1'b0;
    wk_valid          = 1'b0;
    cur_w             = '0;
    cur_k             = '0;
    wk_vector_index   = '0;
    wk_index_complete = complete_q | last_round;
    case (state_q)
      ST_RUN: begin
        busy            = 1'b1;
        wk_valid        = 1'b1;
        wk_vector_index = index_q;
`ifdef SHA256_WK_PRECOMBINE_EN
        cur_w = window_q[0] + k_word;
        cur_k = '0;
`else
        cur_w = window_q[0];
        cur_k = k_word;
`endif
      end
      ST_DONE: wk_vector_index = index_q;
      default: ;
    endcase
  end

endmodule
